// File: rtl/mini_riscv_core.sv
// mini_riscv_core: single-cycle CPU with 16-bit instructions, internal imem/dmem and register file.
// Optional HALT opcode (1110) is enabled by defining MINI_RISCV_HALT_EN.

package mini_riscv_pkg;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
  } instr_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_MUL   = 4'b0100;
  localparam logic [3:0] OP_XOR   = 4'b0101;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_MOV   = 4'b1010;
  localparam logic [3:0] OP_HALT  = 4'b1110;
  localparam logic [3:0] OP_NOP   = 4'b1111;

endpackage

module mini_riscv_core
  import mini_riscv_pkg::*;
#(
  parameter int unsigned REG_COUNT = 8,
  parameter int unsigned REG_WIDTH = 16,
  parameter int unsigned MEM_DEPTH = 16
) (
  input logic clk,
  input logic reset
);

  localparam int unsigned PC_W   = $clog2(MEM_DEPTH);
  localparam int unsigned RIDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  // Architectural state; imem is loaded from outside the core and never written here.
  logic [PC_W-1:0]      PC;
  logic [REG_WIDTH-1:0] regfile     [0:REG_COUNT-1];
  instr_t               m_instr_mem [0:MEM_DEPTH-1];
  logic [REG_WIDTH-1:0] dmem        [0:MEM_DEPTH-1];

  instr_t               instr;
  logic [REG_WIDTH-1:0] op_a;
  logic [REG_WIDTH-1:0] op_b;
  logic [REG_WIDTH-1:0] op_d;
  logic [PC_W-1:0]      mem_addr;

  logic [PC_W-1:0]      pc_d;
  logic                 rf_we;
  logic [RIDX_W-1:0]    rf_waddr;
  logic [REG_WIDTH-1:0] rf_wdata;
  logic                 dm_we;
  logic [REG_WIDTH-1:0] dm_wdata;

`ifdef MINI_RISCV_HALT_EN
  logic halted;
  logic halted_d;
`endif

  assign instr = m_instr_mem[PC];

  // Register read ports: indices past the implemented file read as zero.
  assign op_a = (32'(instr.rs1) < REG_COUNT) ? regfile[instr.rs1[RIDX_W-1:0]] : '0;
  assign op_b = (32'(instr.rs2) < REG_COUNT) ? regfile[instr.rs2[RIDX_W-1:0]] : '0;
  assign op_d = (32'(instr.rd)  < REG_COUNT) ? regfile[instr.rd[RIDX_W-1:0]]  : '0;

  // rs2 doubles as an unsigned 4-bit offset for LOAD/STORE; wraps modulo MEM_DEPTH.
  assign mem_addr = PC_W'(op_a) + PC_W'(instr.rs2);

  assign rf_waddr = instr.rd[RIDX_W-1:0];
  assign dm_wdata = op_d;

  // Decode/execute: next PC and the single register or memory write for this edge.
  always_comb begin
    pc_d     = PC + PC_W'(1);
    rf_we    = 1'b0;
    rf_wdata = '0;
    dm_we    = 1'b0;
`ifdef MINI_RISCV_HALT_EN
    halted_d = halted;
`endif

    case (instr.opcode)
      OP_ADD: begin
        rf_we    = 1'b1;
        rf_wdata = op_a + op_b;
      end
      OP_SUB: begin
        rf_we    = 1'b1;
        rf_wdata = op_a - op_b;
      end
      OP_AND: begin
        rf_we    = 1'b1;
        rf_wdata = op_a & op_b;
      end
      OP_OR: begin
        rf_we    = 1'b1;
        rf_wdata = op_a | op_b;
      end
      OP_MUL: begin
        rf_we    = 1'b1;
        rf_wdata = op_a * op_b;
      end
      OP_XOR: begin
        rf_we    = 1'b1;
        rf_wdata = op_a ^ op_b;
      end
      OP_LOAD: begin
        rf_we    = 1'b1;
        rf_wdata = dmem[mem_addr];
      end
      OP_STORE: begin
        dm_we = 1'b1;
      end
      OP_MOV: begin
        rf_we    = 1'b1;
        rf_wdata = op_a;
      end
      OP_NOP, OP_HALT: begin
      end
      default: begin
      end
    endcase

`ifdef MINI_RISCV_HALT_EN
    // Once halted, the core freezes until reset.
    if (halted || (instr.opcode == OP_HALT)) begin
      pc_d     = PC;
      rf_we    = 1'b0;
      dm_we    = 1'b0;
      halted_d = 1'b1;
    end
`endif

    if (32'(instr.rd) >= REG_COUNT) begin
      rf_we = 1'b0;
    end
  end

  // Reset only rewinds PC (and the halt flag); storage keeps its contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC <= '0;
    end else begin
      PC <= pc_d;
      if (rf_we) begin
        regfile[rf_waddr] <= rf_wdata;
      end
      if (dm_we) begin
        dmem[mem_addr] <= dm_wdata;
      end
    end
  end

`ifdef MINI_RISCV_HALT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else begin
      halted <= halted_d;
    end
  end
`endif

endmodule

// File: tb/tb_mini_riscv_core.sv
// Scoreboard bench for mini_riscv_core: a behavioural ISA model predicts architectural state per edge;
// a monitor compares PC, registers and data memory after every rising edge.

module tb_mini_riscv_core;

  localparam int NREG  = 8;
  localparam int DEPTH = 16;
  localparam int SP_NONE = 0;
  localparam int SP_REG  = 1;
  localparam int SP_DM   = 2;
  localparam int SP_PC   = 3;

`ifdef MINI_RISCV_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  mini_riscv_core #(
    .REG_COUNT(NREG),
    .REG_WIDTH(16),
    .MEM_DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned pc;
    int unsigned rf[16];
    int unsigned dm[16];
    bit          halted;
    int          sk;
    int unsigned si;
    int unsigned sv;
    int          tag;
  } snap_t;

  snap_t exp_q[$];

  int unsigned m_pc;
  int unsigned m_rf[16];
  int unsigned m_dm[16];
  int unsigned m_im[16];
  bit          m_halted;

  int checks  = 0;
  int errors  = 0;
  int edge_no = 0;

  function automatic int unsigned mreg(input int unsigned i);
    return (i < NREG) ? m_rf[4'(i)] : 0;
  endfunction

  // ISA-level reference: execute the instruction at m_pc.
  task automatic model_step();
    int unsigned w, op, rd, rs1, imm, a, b, addr;
    longint unsigned res;
    bit wr;
    w    = m_im[4'(m_pc)];
    op   = w / 4096;
    rd   = (w / 256) % 16;
    rs1  = (w / 16) % 16;
    imm  = w % 16;
    a    = mreg(rs1);
    b    = mreg(imm);
    addr = (a + imm) % DEPTH;
    wr   = 1'b1;
    res  = 0;
    if (HALT_EN && (m_halted || op == 14)) begin
      m_halted = 1'b1;
      return;
    end
    case (op)
      0:  res = 64'(a) + 64'(b);
      1:  res = 64'(a) + 65536 - 64'(b);
      2:  res = 64'(a & b);
      3:  res = 64'(a | b);
      4:  res = 64'(a) * 64'(b);
      5:  res = 64'(a ^ b);
      8:  res = 64'(m_dm[4'(addr)]);
      9:  begin m_dm[4'(addr)] = mreg(rd); wr = 1'b0; end
      10: res = 64'(a);
      default: wr = 1'b0;
    endcase
    if (wr && rd < NREG) m_rf[4'(rd)] = 32'(res % 65536);
    m_pc = (m_pc + 1) % DEPTH;
  endtask

  // Drive one edge's inputs (called just after a falling edge) and queue the expected state.
  task automatic issue(input bit rst, input int sk = SP_NONE, input int unsigned si = 0,
                       input int unsigned sv = 0);
    snap_t s;
    reset = rst;
    if (rst) begin
      m_pc     = 0;
      m_halted = 1'b0;
    end else begin
      model_step();
    end
    edge_no++;
    s.pc     = m_pc;
    s.rf     = m_rf;
    s.dm     = m_dm;
    s.halted = m_halted;
    s.sk     = sk;
    s.si     = si;
    s.sv     = sv;
    s.tag    = edge_no;
    exp_q.push_back(s);
  endtask

  task automatic cyc(input bit rst, input int sk = SP_NONE, input int unsigned si = 0,
                     input int unsigned sv = 0);
    @(negedge clk);
    issue(rst, sk, si, sv);
  endtask

  task automatic load_reg(input int unsigned i, input int unsigned v);
    m_rf[4'(i)] = v % 65536;
    dut.regfile[3'(i)] = 16'(v);
  endtask

  task automatic load_dm(input int unsigned i, input int unsigned v);
    m_dm[4'(i)] = v % 65536;
    dut.dmem[4'(i)] = 16'(v);
  endtask

  task automatic load_im(input int unsigned i, input int unsigned w);
    m_im[4'(i)] = w % 65536;
    dut.m_instr_mem[4'(i)] = 16'(w);
  endtask

  // Random registers and data, NOP-filled program.
  task automatic fill_random();
    for (int i = 0; i < NREG; i++) load_reg(i, $urandom_range(0, 65535));
    for (int i = 0; i < DEPTH; i++) begin
      load_dm(i, $urandom_range(0, 65535));
      load_im(i, 32'h0000_F000);
    end
  endtask

  task automatic check(input string what, input int tag, input int unsigned act,
                       input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", what, tag, act, exp);
    end
  endtask

  // Monitor: after each rising edge, compare the architectural state with the next expectation.
  initial begin
    snap_t s;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        s = exp_q.pop_front();
        check("pc", s.tag, 32'(dut.PC), s.pc);
        for (int j = 0; j < NREG; j++)
          check($sformatf("r%0d", j), s.tag, 32'(dut.regfile[3'(j)]), s.rf[4'(j)]);
        for (int j = 0; j < DEPTH; j++)
          check($sformatf("dmem%0d", j), s.tag, 32'(dut.dmem[4'(j)]), s.dm[4'(j)]);
`ifdef MINI_RISCV_HALT_EN
        check("halted", s.tag, 32'(dut.halted), 32'(s.halted));
`endif
        case (s.sk)
          SP_REG: check("spot_reg", s.tag, 32'(dut.regfile[3'(s.si)]), s.sv);
          SP_DM:  check("spot_dmem", s.tag, 32'(dut.dmem[4'(s.si)]), s.sv);
          SP_PC:  check("spot_pc", s.tag, 32'(dut.PC), s.sv);
          default: ;
        endcase
      end
    end
  end

  initial begin
    reset = 1'b1;

    // Arithmetic chain, load/store/move, reset retention, PC wrap with NOP fill.
    @(negedge clk);
    fill_random();
    load_reg(0, 0);  load_reg(1, 10); load_reg(2, 5);
    load_reg(3, 3);  load_reg(4, 7);
    load_dm(0, 100); load_dm(1, 200); load_dm(2, 300);
    load_im(0, 32'h0512); load_im(1, 32'h4553); load_im(2, 32'h1554);
    load_im(3, 32'h8601); load_im(4, 32'h9602); load_im(5, 32'hA760);
    issue(1'b1, SP_PC, 0, 0);
    cyc(1'b1, SP_REG, 1, 10);
    for (int e = 1; e <= 20; e++) begin
      case (e)
        1, 17:   cyc(1'b0, SP_REG, 5, 15);
        2, 18:   cyc(1'b0, SP_REG, 5, 45);
        3, 19:   cyc(1'b0, SP_REG, 5, 38);
        4:       cyc(1'b0, SP_REG, 6, 200);
        5:       cyc(1'b0, SP_DM, 2, 200);
        6:       cyc(1'b0, SP_REG, 7, 200);
        7:       cyc(1'b0, SP_DM, 0, 100);
        15:      cyc(1'b0, SP_PC, 0, 15);
        16:      cyc(1'b0, SP_PC, 0, 0);
        20:      cyc(1'b0, SP_DM, 1, 200);
        default: cyc(1'b0);
      endcase
    end

    // Edge arithmetic, out-of-range registers, undefined opcode, HALT slot 6, mid-run reset.
    @(negedge clk);
    fill_random();
    load_reg(0, 16'h1234); load_reg(1, 0); load_reg(2, 1);
    load_reg(4, 16'h0100); load_reg(6, 15);
    load_dm(2, 16'hBEEF);
    load_im(0, 32'h1312); load_im(1, 32'h4544); load_im(2, 32'h8763);
    load_im(3, 32'h0912); load_im(4, 32'hA2C0); load_im(5, 32'h7123);
    load_im(6, 32'hE000); load_im(7, 32'h0066);
    issue(1'b1);
    cyc(1'b1);
    cyc(1'b0, SP_REG, 3, 16'hFFFF);
    cyc(1'b0, SP_REG, 5, 0);
    cyc(1'b0, SP_REG, 7, 16'hBEEF);
    cyc(1'b0);
    cyc(1'b0, SP_REG, 2, 0);
    cyc(1'b0);
    cyc(1'b0, SP_PC, 0, HALT_EN ? 6 : 7);
    cyc(1'b0, SP_REG, 0, HALT_EN ? 16'h1234 : 30);
    for (int e = 9; e <= 11; e++) cyc(1'b0);
    cyc(1'b0, SP_PC, 0, HALT_EN ? 6 : 12);
    cyc(1'b1, SP_PC, 0, 0);
    cyc(1'b0, SP_PC, 0, 1);
    cyc(1'b0, SP_PC, 0, 2);

    // Random programs with a reset pulse mid-run.
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      fill_random();
      for (int i = 0; i < DEPTH; i++) load_im(i, $urandom_range(0, 65535));
      issue(1'b1);
      cyc(1'b1);
      for (int e = 1; e <= 26; e++) cyc(e == 10);
    end

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
